// File: rtl/harris_pkg.sv
// ---------------------------------------------------------------------------
// harris_pkg
// Shared constants and types for the Harris corner post-processing stages:
// default frame geometry, datapath widths and the corner_frame_stats FSM
// state encoding.
// ---------------------------------------------------------------------------
package harris_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_V_ACTIVE = 480;

    localparam int COORD_W = 10;
    localparam int FEAT_W  = 18;
    localparam int SUM_W   = 28;
    localparam int COUNT_W = 19;

    // Most negative score: starting point for the per-frame peak search.
    localparam logic signed [FEAT_W-1:0] FEAT_MIN = {1'b1, {(FEAT_W-1){1'b0}}};
    localparam logic [COORD_W-1:0] COORD_ONE = {{(COORD_W-1){1'b0}}, 1'b1};
    localparam logic [COORD_W-1:0] COORD_ZERO = {COORD_W{1'b0}};

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ACCUM = 3'd1,
        ST_DIV_X = 3'd2,
        ST_DIV_Y = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/seq_divider.sv
// ---------------------------------------------------------------------------
// seq_divider
// Restoring unsigned divider, one quotient bit per clock.
// The first step is taken on the edge that samples start, so a division of
// a DIVIDEND_W-bit value occupies exactly DIVIDEND_W cycles, the last of
// which has done high. The quotient register holds the full result from the
// edge that ends the done cycle until the next start.
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   start               load dividend/divisor and perform the first step
//   dividend, divisor   operands (sampled only with start)
//   running             a division is in progress (steps 2..N)
//   done                the current cycle performs the final step
//   quotient            low OUT_W bits of the quotient register
// ---------------------------------------------------------------------------
module seq_divider #(
    parameter int DIVIDEND_W = 28,
    parameter int DIVISOR_W  = 19,
    parameter int OUT_W      = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  running,
    output logic                  done,
    output logic [OUT_W-1:0]      quotient
);

    localparam int CNT_W = $clog2(DIVIDEND_W + 1);

    logic [DIVISOR_W-1:0]  rem;
    logic [DIVIDEND_W-1:0] quo;
    logic [CNT_W-1:0]      cnt;

    logic [DIVISOR_W-1:0]  rem_in;
    logic [DIVIDEND_W-1:0] quo_in;
    logic [DIVISOR_W:0]    shifted;
    logic [DIVISOR_W:0]    trial;
    logic [DIVISOR_W-1:0]  rem_nxt;
    logic [DIVIDEND_W-1:0] quo_nxt;

    assign done     = running && (cnt == CNT_W'(DIVIDEND_W - 1));
    assign quotient = quo[OUT_W-1:0];

    // One restoring step; on start the step works directly on the operands.
    always_comb begin
        rem_in  = start ? {DIVISOR_W{1'b0}} : rem;
        quo_in  = start ? dividend : quo;
        shifted = {rem_in, quo_in[DIVIDEND_W-1]};
        trial   = shifted - {1'b0, divisor};
        if (!trial[DIVISOR_W]) begin
            rem_nxt = trial[DIVISOR_W-1:0];
            quo_nxt = {quo_in[DIVIDEND_W-2:0], 1'b1};
        end else begin
            rem_nxt = shifted[DIVISOR_W-1:0];
            quo_nxt = {quo_in[DIVIDEND_W-2:0], 1'b0};
        end
    end

    // Remainder / quotient shift registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rem <= {DIVISOR_W{1'b0}};
            quo <= {DIVIDEND_W{1'b0}};
        end else if (start || running) begin
            rem <= rem_nxt;
            quo <= quo_nxt;
        end
    end

    // Step counter; cnt counts steps already taken.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            running <= 1'b0;
            cnt     <= {CNT_W{1'b0}};
        end else if (start) begin
            running <= 1'b1;
            cnt     <= {{(CNT_W-1){1'b0}}, 1'b1};
        end else if (done) begin
            running <= 1'b0;
            cnt     <= {CNT_W{1'b0}};
        end else if (running) begin
            cnt <= cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/corner_frame_stats.sv
// ---------------------------------------------------------------------------
// corner_frame_stats
// Per-frame statistics over the Harris corner flag stream: corner count,
// integer centroid, strongest corner and (optionally) bounding box.
// Optional feature macro: CORNER_BBOX_EN builds the bounding-box logic;
// without it the bbox outputs are tied to 0.
// Ports:
//   clk, reset            pixel clock, asynchronous active-high reset
//   clk_en                pixel valid
//   frame_start           pulse marking pixel (0,0); honoured only in IDLE
//   corner_detected       corner flag of the current pixel
//   harris_feature        signed score of the current pixel
//   corner_count          corners in the last completed frame
//   centroid_x/y          floor(sum / count)
//   peak_x/y, peak_feature  first corner holding the maximum score
//   bbox_x/ymin/max       corner bounding box
//   result_valid          one-cycle pulse when the result outputs update
//   busy                  high in ACCUM, DIV_X and DIV_Y
// ---------------------------------------------------------------------------
module corner_frame_stats
    import harris_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int V_ACTIVE = DEF_V_ACTIVE
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clk_en,
    input  logic                     frame_start,
    input  logic                     corner_detected,
    input  logic signed [FEAT_W-1:0] harris_feature,
    output logic [COUNT_W-1:0]       corner_count,
    output logic [COORD_W-1:0]       centroid_x,
    output logic [COORD_W-1:0]       centroid_y,
    output logic [COORD_W-1:0]       peak_x,
    output logic [COORD_W-1:0]       peak_y,
    output logic signed [FEAT_W-1:0] peak_feature,
    output logic [COORD_W-1:0]       bbox_xmin,
    output logic [COORD_W-1:0]       bbox_xmax,
    output logic [COORD_W-1:0]       bbox_ymin,
    output logic [COORD_W-1:0]       bbox_ymax,
    output logic                     result_valid,
    output logic                     busy
);

    state_t state, state_nxt;

    logic [COORD_W-1:0]       x, y;
    logic [COUNT_W-1:0]       count;
    logic [SUM_W-1:0]         sum_x, sum_y;
    logic signed [FEAT_W-1:0] acc_peak_f;
    logic [COORD_W-1:0]       acc_peak_x, acc_peak_y;
    logic [COORD_W-1:0]       cent_x_hold;

    // Frame-start cycle sees the accumulators as already cleared.
    logic                     init, sample, hit, x_last, y_last, last_px, peak_take;
    logic [COORD_W-1:0]       cur_x, cur_y;
    logic [COUNT_W-1:0]       base_count, count_nxt;
    logic [SUM_W-1:0]         base_sx, base_sy;
    logic signed [FEAT_W-1:0] base_pf;
    logic [COORD_W-1:0]       base_px, base_py;

    logic                     div_start, div_running, div_done;
    logic [COORD_W-1:0]       div_quo;

    // Current-pixel view of the accumulators, merging the frame-start clear.
    always_comb begin
        init       = (state == ST_IDLE) && frame_start;
        sample     = clk_en && (init || (state == ST_ACCUM));
        hit        = sample && corner_detected;
        cur_x      = init ? COORD_ZERO : x;
        cur_y      = init ? COORD_ZERO : y;
        x_last     = (cur_x == COORD_W'(H_ACTIVE - 1));
        y_last     = (cur_y == COORD_W'(V_ACTIVE - 1));
        last_px    = sample && x_last && y_last;
        base_count = init ? {COUNT_W{1'b0}} : count;
        base_sx    = init ? {SUM_W{1'b0}} : sum_x;
        base_sy    = init ? {SUM_W{1'b0}} : sum_y;
        base_pf    = init ? FEAT_MIN : acc_peak_f;
        base_px    = init ? COORD_ZERO : acc_peak_x;
        base_py    = init ? COORD_ZERO : acc_peak_y;
        count_nxt  = base_count + {{(COUNT_W-1){1'b0}}, hit};
        peak_take  = hit && (harris_feature > base_pf);
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (init && last_px) begin
                    state_nxt = (count_nxt != {COUNT_W{1'b0}}) ? ST_DIV_X : ST_DONE;
                end else if (init) begin
                    state_nxt = ST_ACCUM;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_ACCUM: begin
                if (last_px) begin
                    state_nxt = (count_nxt != {COUNT_W{1'b0}}) ? ST_DIV_X : ST_DONE;
                end else begin
                    state_nxt = ST_ACCUM;
                end
            end
            ST_DIV_X: state_nxt = div_done ? ST_DIV_Y : ST_DIV_X;
            ST_DIV_Y: state_nxt = div_done ? ST_DONE : ST_DIV_Y;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // FSM outputs: busy flag and divider kick in the first cycle of each DIV state.
    always_comb begin
        busy      = 1'b0;
        div_start = 1'b0;
        case (state)
            ST_ACCUM: busy = 1'b1;
            ST_DIV_X, ST_DIV_Y: begin
                busy      = 1'b1;
                div_start = !div_running;
            end
            default: begin
                busy      = 1'b0;
                div_start = 1'b0;
            end
        endcase
    end

    // Raster position, count, sums and peak accumulation.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x          <= COORD_ZERO;
            y          <= COORD_ZERO;
            count      <= {COUNT_W{1'b0}};
            sum_x      <= {SUM_W{1'b0}};
            sum_y      <= {SUM_W{1'b0}};
            acc_peak_f <= {FEAT_W{1'b0}};
            acc_peak_x <= COORD_ZERO;
            acc_peak_y <= COORD_ZERO;
        end else if (init || sample) begin
            if (sample) begin
                x <= x_last ? COORD_ZERO : cur_x + COORD_ONE;
                y <= x_last ? (y_last ? COORD_ZERO : cur_y + COORD_ONE) : cur_y;
            end else begin
                x <= cur_x;
                y <= cur_y;
            end
            count <= count_nxt;
            sum_x <= hit ? base_sx + {{(SUM_W-COORD_W){1'b0}}, cur_x} : base_sx;
            sum_y <= hit ? base_sy + {{(SUM_W-COORD_W){1'b0}}, cur_y} : base_sy;
            if (peak_take) begin
                acc_peak_f <= harris_feature;
                acc_peak_x <= cur_x;
                acc_peak_y <= cur_y;
            end else begin
                acc_peak_f <= base_pf;
                acc_peak_x <= base_px;
                acc_peak_y <= base_py;
            end
        end
    end

    seq_divider #(
        .DIVIDEND_W (SUM_W),
        .DIVISOR_W  (COUNT_W),
        .OUT_W      (COORD_W)
    ) u_div (
        .clk      (clk),
        .reset    (reset),
        .start    (div_start),
        .dividend ((state == ST_DIV_Y) ? sum_y : sum_x),
        .divisor  (count),
        .running  (div_running),
        .done     (div_done),
        .quotient (div_quo)
    );

    // The X quotient is still intact when the Y division is kicked off.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cent_x_hold <= COORD_ZERO;
        end else if ((state == ST_DIV_Y) && div_start) begin
            cent_x_hold <= div_quo;
        end
    end

    // Result registers, loaded together in DONE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result_valid <= 1'b0;
            corner_count <= {COUNT_W{1'b0}};
            centroid_x   <= COORD_ZERO;
            centroid_y   <= COORD_ZERO;
            peak_x       <= COORD_ZERO;
            peak_y       <= COORD_ZERO;
            peak_feature <= {FEAT_W{1'b0}};
        end else begin
            result_valid <= (state == ST_DONE);
            if (state == ST_DONE) begin
                corner_count <= count;
                if (count != {COUNT_W{1'b0}}) begin
                    centroid_x   <= cent_x_hold;
                    centroid_y   <= div_quo;
                    peak_x       <= acc_peak_x;
                    peak_y       <= acc_peak_y;
                    peak_feature <= acc_peak_f;
                end else begin
                    centroid_x   <= COORD_ZERO;
                    centroid_y   <= COORD_ZERO;
                    peak_x       <= COORD_ZERO;
                    peak_y       <= COORD_ZERO;
                    peak_feature <= {FEAT_W{1'b0}};
                end
            end
        end
    end

`ifdef CORNER_BBOX_EN
    logic [COORD_W-1:0] bb_xmin, bb_xmax, bb_ymin, bb_ymax;
    logic [COORD_W-1:0] base_xmin, base_xmax, base_ymin, base_ymax;

    // Bounding-box view with the frame-start initial values merged in.
    always_comb begin
        base_xmin = init ? {COORD_W{1'b1}} : bb_xmin;
        base_xmax = init ? COORD_ZERO : bb_xmax;
        base_ymin = init ? {COORD_W{1'b1}} : bb_ymin;
        base_ymax = init ? COORD_ZERO : bb_ymax;
    end

    // Bounding-box accumulation.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bb_xmin <= COORD_ZERO;
            bb_xmax <= COORD_ZERO;
            bb_ymin <= COORD_ZERO;
            bb_ymax <= COORD_ZERO;
        end else if (init || sample) begin
            bb_xmin <= (hit && (cur_x < base_xmin)) ? cur_x : base_xmin;
            bb_xmax <= (hit && (cur_x > base_xmax)) ? cur_x : base_xmax;
            bb_ymin <= (hit && (cur_y < base_ymin)) ? cur_y : base_ymin;
            bb_ymax <= (hit && (cur_y > base_ymax)) ? cur_y : base_ymax;
        end
    end

    // Bounding-box result registers; an empty frame reports 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bbox_xmin <= COORD_ZERO;
            bbox_xmax <= COORD_ZERO;
            bbox_ymin <= COORD_ZERO;
            bbox_ymax <= COORD_ZERO;
        end else if (state == ST_DONE) begin
            if (count != {COUNT_W{1'b0}}) begin
                bbox_xmin <= bb_xmin;
                bbox_xmax <= bb_xmax;
                bbox_ymin <= bb_ymin;
                bbox_ymax <= bb_ymax;
            end else begin
                bbox_xmin <= COORD_ZERO;
                bbox_xmax <= COORD_ZERO;
                bbox_ymin <= COORD_ZERO;
                bbox_ymax <= COORD_ZERO;
            end
        end
    end
`else
    assign bbox_xmin = COORD_ZERO;
    assign bbox_xmax = COORD_ZERO;
    assign bbox_ymin = COORD_ZERO;
    assign bbox_ymax = COORD_ZERO;
`endif

endmodule

// File: doc/corner_frame_stats.md
# corner_frame_stats

Per-frame corner statistics stage that sits directly downstream of the Harris corner detector. It consumes the per-pixel `corner_detected` flag and `harris_feature` score and tracks the raster position internally. At end of frame it produces the corner count, the integer centroid, the strongest corner, and optionally the bounding box. Results feed the overlay/VGA annotation logic and the HPS-readable status registers.

## Interface
- `H_ACTIVE`, default 640: active pixels per line.
- `V_ACTIVE`, default 480: active lines per frame.
- `clk`  in  1  pixel-domain clock.
- `reset`  in  1  asynchronous, active-high reset.
- `clk_en`  in  1  pixel valid; inputs are sampled only when high.
- `frame_start`  in  1  one-cycle pulse marking pixel (0,0) of a frame.
- `corner_detected`  in  1  corner flag for the current pixel.
- `harris_feature`  in  18 signed  Harris score for the current pixel.
- `corner_count`  out  19  corners in the last completed frame.
- `centroid_x`  out  10  floor(sum_x / count).
- `centroid_y`  out  10  floor(sum_y / count).
- `peak_x`, `peak_y`  out  10 each  position of the maximum-score corner.
- `peak_feature`  out  18 signed  score of that corner.
- `bbox_xmin`, `bbox_xmax`, `bbox_ymin`, `bbox_ymax`  out  10 each  corner bounding box (see Configuration).
- `result_valid`  out  1  one-cycle pulse when all outputs update.
- `busy`  out  1  high in ACCUM, DIV_X and DIV_Y.

## Operation
- FSM states:
  - IDLE: waits for `frame_start`.
  - ACCUM: raster counting and accumulation.
  - DIV_X: 28 cycles.
  - DIV_Y: 28 cycles.
  - DONE: 1 cycle.
- IDLE→ACCUM on `frame_start`. Counters are cleared to (0,0); if `clk_en` is also high that cycle, that pixel is pixel (0,0) and is accumulated.
- ACCUM, on each `clk_en`: x increments and wraps at H_ACTIVE-1, with y incrementing on wrap. Gaps in `clk_en` hold all counters.
- When `corner_detected` is high on a sampled pixel:
  - count += 1; sum_x += x; sum_y += y.
  - Bbox min/max are updated.
  - Peak updates only if `harris_feature` > stored peak (strict greater-than, so the first occurrence wins ties). The stored peak initialises to the most negative value at frame start.
- End of frame is the sampled pixel at (H_ACTIVE-1, V_ACTIVE-1).
  - count ≠ 0: go to DIV_X.
  - count = 0: go straight to DONE. Centroid, peak and bbox outputs are 0.
- DIV_X / DIV_Y: a shared restoring divider divides a 28-bit dividend by the 19-bit count, one quotient bit per cycle; the low 10 quotient bits are kept.
- DONE: all output registers load together, `result_valid` = 1, next state IDLE.
- Outputs hold their values until the next DONE.
- `frame_start` outside IDLE is ignored. A frame already in ACCUM restarts only through reset. Frames arriving during DIV_X/DIV_Y are skipped.
- Widths:
  - sum_x, sum_y: 28-bit unsigned (max 639·307200 < 2^28).
  - count: 19-bit; cannot overflow for the default geometry.

## Timing
- Reset: state IDLE; all outputs, counters and accumulators are 0; `result_valid` and `busy` are 0.
- Reset mid-operation aborts immediately; no `result_valid` is produced for that frame.
- Latency from the clock edge that samples the last pixel to `result_valid` high:
  - count ≠ 0: 57 cycles (28 + 28 + 1).
  - count = 0: 1 cycle.
- `result_valid` is exactly one cycle wide. `busy` falls in the DONE cycle.
- Upstream alignment of `corner_detected` and `harris_feature` to the same pixel is the producer's responsibility. This block treats them as coincident.

## Configuration
- `CORNER_BBOX_EN` defined: bbox min/max registers and compare logic are built. Initial values at frame start: min = all-ones, max = 0. These are forced to 0 at DONE when count = 0.
- `CORNER_BBOX_EN` undefined: no bbox logic is built; the four bbox outputs are tied to 0.

## Structure
- Shared package `harris_pkg` holds:
  - Default H_ACTIVE/V_ACTIVE.
  - Coordinate width (10), feature width (18), sum width (28), count width (19).
  - The FSM state enum.
- Sub-module `seq_divider`: a parameterised restoring divider with a start/done handshake, instantiated once and time-shared between DIV_X and DIV_Y.

## Test plan
All scenarios use H_ACTIVE=8, V_ACTIVE=4.
- Single corner at (3,2), feature 100 → count 1, centroid (3,2), peak (3,2,100), bbox x 3..3, y 2..2; `result_valid` 57 cycles after the last pixel.
- Corners at (0,0) and (7,3) → count 2, centroid (3,1) (floor of 3.5/1.5), bbox 0..7, 0..3.
- No corners → count 0, all stats 0, `result_valid` 1 cycle after the last pixel.
- Equal feature 50 at (1,0) and (5,2), all others lower → peak (1,0,50).
- `frame_start` pulsed during DIV_X → ignored, first frame's results delivered unchanged, `busy` returns to 0. A later `frame_start` in IDLE is accepted.
- Random `clk_en` gaps plus reset asserted mid-ACCUM → outputs 0, no `result_valid`. A following clean frame with one corner at (2,1) reports count 1, centroid (2,1).
